// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate BIST controller.
// The optional signature feature is enabled with BIST_SIGNATURE_EN.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } bist_state_t;

    localparam int unsigned MISR_W   = 8;
    localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;
    localparam int unsigned SETTLE_W = 4;

    // One MISR step: shift left, fold the feedback polynomial on carry-out, xor in the new bit.
    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s, input logic din);
        return {s[MISR_W-2:0], 1'b0}
             ^ (s[MISR_W-1] ? MISR_POLY : '0)
             ^ {{(MISR_W-1){1'b0}}, din};
    endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Harness-side bus between the BIST controller and the gate under test.
// BIST_SIGNATURE_EN adds the signature output.
interface gate_bist_ctrl_if #(
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned CNT_W  = 3
);
    logic                     start;
    logic [NUM_IN-1:0]        dut_in;
    logic                     dut_out;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [(2**NUM_IN)-1:0]   fail_vec;
    logic [CNT_W-1:0]         err_count;
`ifdef BIST_SIGNATURE_EN
    logic [7:0]               signature;

    modport master (input start, dut_out,
                    output dut_in, busy, done, pass, fail_vec, err_count, signature);
    modport slave  (output start, dut_out,
                    input dut_in, busy, done, pass, fail_vec, err_count, signature);
`else
    modport master (input start, dut_out,
                    output dut_in, busy, done, pass, fail_vec, err_count);
    modport slave  (output start, dut_out,
                    input dut_in, busy, done, pass, fail_vec, err_count);
`endif
endinterface

// File: rtl/gate_bist_ctrl_misr.sv
// 8-bit multiple-input signature register compressing the sampled gate outputs.
module bist_misr
    import gate_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = misr_step(sig_q, din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller: walks every input pattern through a gate and checks it against TRUTH_TABLE.
// BIST_SIGNATURE_EN additionally compresses the sampled outputs into an 8-bit MISR signature.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int unsigned              NUM_IN        = 2,
    parameter logic [(2**NUM_IN)-1:0]   TRUTH_TABLE   = 4'b1000,
    parameter int unsigned              SETTLE_CYCLES = 2,
    parameter int unsigned              CNT_W         = 3
) (
    input logic             clk,
    input logic             rst_n,
    gate_bist_ctrl_if.master bus
);

    localparam int unsigned PAT = 2**NUM_IN;
    localparam logic [NUM_IN-1:0]   IDX_LAST    = NUM_IN'(PAT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        SETTLE_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

    bist_state_t         state_q, state_d;
    logic [NUM_IN-1:0]   idx_q, idx_d;
    logic [SETTLE_W-1:0] scnt_q, scnt_d;
    logic [NUM_IN-1:0]   dut_in_q, dut_in_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [PAT-1:0]      fail_vec_q, fail_vec_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic                mismatch_c;
    logic                accept_c;

    // Four-state compare: a floating or unknown gate output is a defect.
    assign mismatch_c = (state_q == SAMPLE) && (bus.dut_out !== TRUTH_TABLE[idx_q]);
    assign accept_c   = (state_q == IDLE) && bus.start;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        scnt_d      = scnt_q;
        dut_in_d    = dut_in_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_vec_d  = fail_vec_q;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                dut_in_d = '0;
                if (bus.start) begin
                    state_d     = APPLY;
                    idx_d       = '0;
                    fail_vec_d  = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            APPLY: begin
                scnt_d  = '0;
                state_d = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                if (scnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    scnt_d = scnt_q + SETTLE_W'(1);
                end
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    fail_vec_d[idx_q] = 1'b1;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fail_vec_d == '0);
                end else begin
                    state_d  = APPLY;
                    idx_d    = idx_q + NUM_IN'(1);
                    dut_in_d = idx_q + NUM_IN'(1);
                end
            end
            DONE: begin
                state_d  = IDLE;
                dut_in_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            scnt_q      <= '0;
            dut_in_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_vec_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            scnt_q      <= scnt_d;
            dut_in_q    <= dut_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_vec_q  <= fail_vec_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_vec  = fail_vec_q;
    assign bus.err_count = err_count_q;

`ifdef BIST_SIGNATURE_EN
    logic misr_din_c;

    // Anything but a clean 0 enters the signature as 1.
    assign misr_din_c = (bus.dut_out === 1'b0) ? 1'b0 : 1'b1;

    bist_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_c),
        .en    (state_q == SAMPLE),
        .din   (misr_din_c),
        .sig   (bus.signature)
    );
`else
    logic unused_c;
    assign unused_c = accept_c;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl; build with BIST_SIGNATURE_EN to also check the signature.
module tb_gate_bist_ctrl;

    localparam int unsigned NUM_IN = 2;
    localparam int unsigned PAT    = 4;
    localparam int unsigned CNT_W  = 3;
    localparam logic [3:0]  TT     = 4'b1000;
`ifdef BIST_SIGNATURE_EN
    localparam int unsigned SETTLE = 0;
`else
    localparam int unsigned SETTLE = 2;
`endif
    localparam int unsigned RUN_LEN = PAT * (SETTLE + 2);

    localparam int G_AND  = 0;
    localparam int G_T0   = 1;
    localparam int G_T1   = 2;
    localparam int G_Z    = 3;
    localparam int G_FUNC = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         mode  = G_AND;
    logic [3:0] func  = 4'h0;
    int         n_assert = 0;
    int         n_fail   = 0;
`ifdef BIST_SIGNATURE_EN
    logic [7:0] sig_good;
    logic [7:0] sig_t0;
`endif

    always #5 clk = ~clk;

    gate_bist_ctrl_if #(.NUM_IN(NUM_IN), .CNT_W(CNT_W)) bif ();

    gate_bist_ctrl #(
        .NUM_IN        (NUM_IN),
        .TRUTH_TABLE   (TT),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    function automatic logic gate_val(input int m, input logic [3:0] f, input int p);
        logic [1:0] v;
        v = 2'(p);
        case (m)
            G_AND:   return v[0] & v[1];
            G_T0:    return 1'b0;
            G_T1:    return 1'b1;
            G_Z:     return 1'bz;
            default: return f[v];
        endcase
    endfunction

    always_comb bif.dut_out = gate_val(mode, func, int'(bif.dut_in));

    function automatic logic [3:0] exp_fail(input int m, input logic [3:0] f);
        logic [3:0] fv;
        logic       o;
        for (int p = 0; p < PAT; p++) begin
            o     = gate_val(m, f, p);
            fv[p] = (o !== TT[p]);
        end
        return fv;
    endfunction

    function automatic logic [7:0] exp_sig(input int m, input logic [3:0] f);
        int s;
        int b;
        s = 0;
        for (int p = 0; p < PAT; p++) begin
            b = (gate_val(m, f, p) === 1'b0) ? 0 : 1;
            s = ((s << 1) ^ (((s & 128) != 0) ? 'h11D : 0) ^ b) & 'hFF;
        end
        return 8'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int m, input logic [3:0] f, input bit glitch);
        int         n;
        int         cnt [PAT];
        logic [3:0] efv;
        bit         seen;
        mode = m;
        func = f;
        efv  = exp_fail(m, f);
        foreach (cnt[i]) cnt[i] = 0;
        @(negedge clk) bif.start = 1'b1;
        @(negedge clk) bif.start = 1'b0;
        chk("busy_after_accept", 32'(bif.busy), 32'd1);
        chk("fail_vec_cleared", 32'(bif.fail_vec), 32'd0);
        cnt[bif.dut_in]++;
        n    = 0;
        seen = 1'b0;
        while (n < RUN_LEN + 20) begin
            @(negedge clk);
            n++;
            if (glitch && n == 5) bif.start = 1'b1;
            if (n == 6)           bif.start = 1'b0;
            if (bif.done) begin
                seen = 1'b1;
                break;
            end
            cnt[bif.dut_in]++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("run_length", 32'(n), 32'(RUN_LEN));
        for (int p = 0; p < PAT; p++) chk($sformatf("hold_pat%0d", p), 32'(cnt[p]), 32'(SETTLE + 2));
        chk("busy_in_done", 32'(bif.busy), 32'd0);
        chk("fail_vec", 32'(bif.fail_vec), 32'(efv));
        chk("err_count", 32'(bif.err_count), 32'($countones(efv)));
        chk("pass", 32'(bif.pass), 32'(efv == 4'h0));
`ifdef BIST_SIGNATURE_EN
        chk("signature", 32'(bif.signature), 32'(exp_sig(m, f)));
`endif
        @(negedge clk);
        chk("done_pulse_1cyc", 32'(bif.done), 32'd0);
        chk("dut_in_idle", 32'(bif.dut_in), 32'd0);
        chk("fail_vec_held", 32'(bif.fail_vec), 32'(efv));
        chk("pass_held", 32'(bif.pass), 32'(efv == 4'h0));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dut_in"},    32'(bif.dut_in), 32'd0);
        chk({tag, "_busy"},      32'(bif.busy), 32'd0);
        chk({tag, "_done"},      32'(bif.done), 32'd0);
        chk({tag, "_pass"},      32'(bif.pass), 32'd0);
        chk({tag, "_fail_vec"},  32'(bif.fail_vec), 32'd0);
        chk({tag, "_err_count"}, 32'(bif.err_count), 32'd0);
`ifdef BIST_SIGNATURE_EN
        chk({tag, "_signature"}, 32'(bif.signature), 32'd0);
`endif
    endtask

    initial begin
        bit saw_done;
        bif.start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(G_AND, 4'h0, 1'b0);
`ifdef BIST_SIGNATURE_EN
        sig_good = bif.signature;
`endif
        run(G_T0, 4'h0, 1'b0);
`ifdef BIST_SIGNATURE_EN
        sig_t0 = bif.signature;
        chk("sig_stuck0_differs", 32'(sig_t0 != sig_good), 32'd1);
`endif
        run(G_T1, 4'h0, 1'b0);
        run(G_Z, 4'h0, 1'b0);
        run(G_AND, 4'h0, 1'b1);

        // Abort mid-run: nothing may survive and no done may appear.
        mode = G_T1;
        @(negedge clk) bif.start = 1'b1;
        @(negedge clk) bif.start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        saw_done = 1'b0;
        repeat (RUN_LEN + 4) begin
            @(negedge clk);
            if (bif.done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (RUN_LEN + 4) begin
            @(negedge clk);
            if (bif.done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        check_reset_vals("after_abort");

        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run(G_FUNC, 4'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
